// File: rtl/score_ram_neighbour_reader_if.sv
// Bundle of request, score-RAM read and neighbour-result signals for the NW
// score RAM neighbour reader. The slave modport is the reader itself; the
// master modport is its environment (fill controller, RAM and cell scorer).
interface score_ram_neighbour_reader_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic [IDX_W-1:0]  row_i;
  logic [IDX_W-1:0]  col_j;
  logic              ready;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] diag;
  logic [DATA_W-1:0] up;
  logic [DATA_W-1:0] left;
  logic              valid;
  logic              err;
  logic [1:0]        phase;

  modport slave (
    input  req, row_i, col_j, ram_dout,
    output ready, ram_rd_en, ram_addr, diag, up, left, valid, err, phase
  );

  modport master (
    output req, row_i, col_j, ram_dout,
    input  ready, ram_rd_en, ram_addr, diag, up, left, valid, err, phase
  );
endinterface

// File: rtl/score_ram_neighbour_reader.sv
// Read-side sequencer for the NW score RAM. For an accepted cell (i,j) it
// reads diag (i-1,j-1), up (i-1,j) and left (i,j-1) on three consecutive
// cycles, captures the returned scores one cycle later each, and pulses
// valid once all three are held. Illegal cells are rejected with err.
module score_ram_neighbour_reader #(
  parameter int unsigned N      = 8,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input logic                        clk,
  input logic                        rst,
  score_ram_neighbour_reader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRdDiag,
    StRdUp,
    StRdLeft,
    StCapLast,
    StDone
  } state_e;

  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(N);
  localparam int unsigned      Stride = N + 1;
  localparam logic [IDX_W-1:0] One    = IDX_W'(1);

  state_e           state;
  logic [IDX_W-1:0] row_q;
  logic [IDX_W-1:0] col_q;
  logic             req_bad;

  // Row-major address of cell (r,c); widened before the multiply so legal
  // indices never wrap.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
    return ADDR_W'(32'(r) * Stride + 32'(c));
  endfunction

  // Row 0 / column 0 have no upper/left neighbours; indices past N are off-matrix.
  always_comb begin
    req_bad = (bus.row_i == '0) || (bus.col_j == '0) ||
              (bus.row_i > MaxIdx) || (bus.col_j > MaxIdx);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      row_q         <= '0;
      col_q         <= '0;
      bus.ready     <= 1'b1;
      bus.ram_rd_en <= 1'b0;
      bus.ram_addr  <= '0;
      bus.diag      <= {DATA_W{1'b0}};
      bus.up        <= {DATA_W{1'b0}};
      bus.left      <= {DATA_W{1'b0}};
      bus.valid     <= 1'b0;
      bus.err       <= 1'b0;
      bus.phase     <= 2'd3;
    end else begin
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.req) begin
            if (req_bad) begin
              bus.err <= 1'b1;
            end else begin
              row_q         <= bus.row_i;
              col_q         <= bus.col_j;
              state         <= StRdDiag;
              bus.ready     <= 1'b0;
              bus.ram_rd_en <= 1'b1;
              bus.ram_addr  <= cell_addr(bus.row_i - One, bus.col_j - One);
              bus.phase     <= 2'd0;
            end
          end
        end
        StRdDiag: begin
          state        <= StRdUp;
          bus.ram_addr <= cell_addr(row_q - One, col_q);
          bus.phase    <= 2'd1;
        end
        StRdUp: begin
          // Diagonal read data returns now.
          state        <= StRdLeft;
          bus.ram_addr <= cell_addr(row_q, col_q - One);
          bus.phase    <= 2'd2;
          bus.diag     <= bus.ram_dout;
        end
        StRdLeft: begin
          state         <= StCapLast;
          bus.ram_rd_en <= 1'b0;
          bus.phase     <= 2'd3;
          bus.up        <= bus.ram_dout;
        end
        StCapLast: begin
          state     <= StDone;
          bus.valid <= 1'b1;
          bus.left  <= bus.ram_dout;
        end
        StDone: begin
          state     <= StIdle;
          bus.ready <= 1'b1;
        end
        default: begin
          state         <= StIdle;
          bus.ready     <= 1'b1;
          bus.ram_rd_en <= 1'b0;
          bus.phase     <= 2'd3;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_ram_neighbour_reader.sv
// Directed bench for score_ram_neighbour_reader with N=8 and a synchronous
// RAM model preloaded with mem[a] = a - 40.
module tb_score_ram_neighbour_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  score_ram_neighbour_reader_if #(.N(8), .IDX_W(4), .ADDR_W(7), .DATA_W(8)) bus ();

  score_ram_neighbour_reader #(.N(8), .IDX_W(4), .ADDR_W(7), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [128];

  // Synchronous-read score RAM.
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_dout <= mem[bus.ram_addr];
  end

  // Per-cycle observations; index k is the sample taken just after edge E<k>.
  logic [6:0] o_addr  [16];
  logic       o_rd    [16];
  logic       o_ready [16];
  logic       o_valid [16];
  logic       o_err   [16];
  logic [1:0] o_phase [16];
  logic [7:0] o_diag  [16];
  logic [7:0] o_up    [16];
  logic [7:0] o_left  [16];

  // Present (i,j) before E0 and record ncyc samples. With b2b the request is
  // held and switched to (i2,j2) as soon as ready returns. rst_at pulses reset
  // so that it is sampled on edge E<rst_at+1>.
  task automatic run(input logic [3:0] i, input logic [3:0] j,
                     input logic [3:0] i2, input logic [3:0] j2,
                     input bit b2b, input int rst_at, input int ncyc);
    bit switched = 1'b0;
    bus.req   = 1'b1;
    bus.row_i = i;
    bus.col_j = j;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      o_addr[k]  = bus.ram_addr;
      o_rd[k]    = bus.ram_rd_en;
      o_ready[k] = bus.ready;
      o_valid[k] = bus.valid;
      o_err[k]   = bus.err;
      o_phase[k] = bus.phase;
      o_diag[k]  = bus.diag;
      o_up[k]    = bus.up;
      o_left[k]  = bus.left;
      if (!b2b && k == 0) bus.req = 1'b0;
      if (b2b && switched && !bus.ready) bus.req = 1'b0;
      if (b2b && !switched && k > 0 && bus.ready) begin
        bus.row_i = i2;
        bus.col_j = j2;
        switched  = 1'b1;
      end
      rst = (k == rst_at);
    end
    bus.req = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    checks++; if (bus.ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", bus.ram_rd_en); end
    checks++; if (bus.ram_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.ram_addr); end
    checks++; if ({bus.diag, bus.up, bus.left} !== 24'h0) begin errors++; $display("FAIL reset_scores got %h want 000000", {bus.diag, bus.up, bus.left}); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if (bus.phase !== 2'd3) begin errors++; $display("FAIL reset_phase got %0d want 3", bus.phase); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [6:0] ea [3];
    ea = '{7'd0, 7'd1, 7'd9};
    run(4'd1, 4'd1, 4'd0, 4'd0, 1'b0, -1, 8);
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_addr[k] !== ea[k]) begin errors++; $display("FAIL single_addr%0d got %0d want %0d", k, o_addr[k], ea[k]); end
    end
    for (int k = 0; k < 8; k++) begin
      checks++; if (o_rd[k] !== (k < 3)) begin errors++; $display("FAIL single_rd_en k=%0d got %b want %b", k, o_rd[k], k < 3); end
      checks++; if (o_valid[k] !== (k == 4)) begin errors++; $display("FAIL single_valid k=%0d got %b want %b", k, o_valid[k], k == 4); end
    end
    checks++; if (o_diag[4] !== 8'hD8) begin errors++; $display("FAIL single_diag got %h want d8", o_diag[4]); end
    checks++; if (o_up[4] !== 8'hD9) begin errors++; $display("FAIL single_up got %h want d9", o_up[4]); end
    checks++; if (o_left[4] !== 8'hE1) begin errors++; $display("FAIL single_left got %h want e1", o_left[4]); end
  endtask

  task automatic test_mid_cell();
    logic [6:0] ea [3];
    logic [1:0] ep [6];
    int first_ready;
    int nvalid;
    ea = '{7'd22, 7'd23, 7'd31};
    ep = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    run(4'd3, 4'd5, 4'd0, 4'd0, 1'b0, -1, 9);
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_addr[k] !== ea[k]) begin errors++; $display("FAIL mid_addr%0d got %0d want %0d", k, o_addr[k], ea[k]); end
    end
    for (int k = 0; k < 6; k++) begin
      checks++; if (o_phase[k] !== ep[k]) begin errors++; $display("FAIL mid_phase k=%0d got %0d want %0d", k, o_phase[k], ep[k]); end
    end
    first_ready = -1;
    nvalid = 0;
    for (int k = 8; k >= 0; k--) if (o_ready[k]) first_ready = k;
    for (int k = 0; k < 9; k++) if (o_valid[k]) nvalid++;
    // Ready returns after E5, so the earliest next accept is E6.
    checks++; if (first_ready + 1 !== 6) begin errors++; $display("FAIL mid_next_accept got E%0d want E6", first_ready + 1); end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL mid_valid_count got %0d want 1", nvalid); end
    checks++; if ({o_diag[8], o_up[8], o_left[8]} !== 24'hEEEFF7) begin errors++; $display("FAIL mid_scores got %h want eeeff7", {o_diag[8], o_up[8], o_left[8]}); end
  endtask

  task automatic test_reject();
    logic [3:0] ri [3];
    logic [3:0] cj [3];
    ri = '{4'd0, 4'd4, 4'd9};
    cj = '{4'd4, 4'd0, 4'd2};
    for (int t = 0; t < 3; t++) begin
      run(ri[t], cj[t], 4'd0, 4'd0, 1'b0, -1, 4);
      checks++; if (o_err[0] !== 1'b1) begin errors++; $display("FAIL reject%0d_err got %b want 1", t, o_err[0]); end
      checks++; if (o_err[1] !== 1'b0) begin errors++; $display("FAIL reject%0d_err_len got %b want 0", t, o_err[1]); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (o_rd[k] !== 1'b0 || o_ready[k] !== 1'b1 || o_valid[k] !== 1'b0) begin
          errors++; $display("FAIL reject%0d_idle k=%0d got rd=%b ready=%b valid=%b want rd=0 ready=1 valid=0", t, k, o_rd[k], o_ready[k], o_valid[k]);
        end
      end
      checks++; if ({o_diag[3], o_up[3], o_left[3]} !== 24'hEEEFF7) begin errors++; $display("FAIL reject%0d_hold got %h want eeeff7", t, {o_diag[3], o_up[3], o_left[3]}); end
    end
  endtask

  task automatic test_corner();
    logic [6:0] ea [3];
    ea = '{7'd70, 7'd71, 7'd79};
    run(4'd8, 4'd8, 4'd0, 4'd0, 1'b0, -1, 6);
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_addr[k] !== ea[k]) begin errors++; $display("FAIL corner_addr%0d got %0d want %0d", k, o_addr[k], ea[k]); end
    end
    checks++; if (o_valid[4] !== 1'b1) begin errors++; $display("FAIL corner_valid got %b want 1", o_valid[4]); end
    checks++; if ({o_diag[4], o_up[4], o_left[4]} !== 24'h1E1F27) begin errors++; $display("FAIL corner_scores got %h want 1e1f27", {o_diag[4], o_up[4], o_left[4]}); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ea [6];
    int         ek [6];
    ea = '{7'd10, 7'd11, 7'd19, 7'd11, 7'd12, 7'd20};
    ek = '{0, 1, 2, 6, 7, 8};
    run(4'd2, 4'd2, 4'd2, 4'd3, 1'b1, -1, 13);
    for (int n = 0; n < 6; n++) begin
      checks++; if (o_rd[ek[n]] !== 1'b1 || o_addr[ek[n]] !== ea[n]) begin
        errors++; $display("FAIL b2b_addr%0d got rd=%b addr=%0d want rd=1 addr=%0d", n, o_rd[ek[n]], o_addr[ek[n]], ea[n]);
      end
    end
    for (int k = 0; k < 13; k++) begin
      checks++; if (o_valid[k] !== (k == 4 || k == 10)) begin errors++; $display("FAIL b2b_valid k=%0d got %b want %b", k, o_valid[k], k == 4 || k == 10); end
      checks++; if (o_valid[k] === 1'b1 && o_err[k] === 1'b1) begin errors++; $display("FAIL b2b_valid_err k=%0d got both high want exclusive", k); end
    end
    checks++; if ({o_diag[4], o_up[4], o_left[4]} !== 24'hE2E3EB) begin errors++; $display("FAIL b2b_scores1 got %h want e2e3eb", {o_diag[4], o_up[4], o_left[4]}); end
    checks++; if ({o_diag[10], o_up[10], o_left[10]} !== 24'hE3E4EC) begin errors++; $display("FAIL b2b_scores2 got %h want e3e4ec", {o_diag[10], o_up[10], o_left[10]}); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] ea [3];
    int         nvalid;
    ea = '{7'd1, 7'd2, 7'd10};
    run(4'd5, 4'd5, 4'd0, 4'd0, 1'b0, 1, 10);
    checks++; if (o_ready[2] !== 1'b1 || o_rd[2] !== 1'b0 || o_phase[2] !== 2'd3) begin
      errors++; $display("FAIL rstmid_ctrl got ready=%b rd=%b phase=%0d want ready=1 rd=0 phase=3", o_ready[2], o_rd[2], o_phase[2]);
    end
    checks++; if ({o_diag[2], o_up[2], o_left[2]} !== 24'h0 || o_addr[2] !== 7'd0) begin
      errors++; $display("FAIL rstmid_data got scores=%h addr=%0d want 000000 addr=0", {o_diag[2], o_up[2], o_left[2]}, o_addr[2]);
    end
    nvalid = 0;
    for (int k = 2; k < 10; k++) if (o_valid[k]) nvalid++;
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL rstmid_no_valid got %0d want 0", nvalid); end
    run(4'd1, 4'd2, 4'd0, 4'd0, 1'b0, -1, 6);
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_addr[k] !== ea[k]) begin errors++; $display("FAIL rstmid_next_addr%0d got %0d want %0d", k, o_addr[k], ea[k]); end
    end
    checks++; if (o_valid[4] !== 1'b1) begin errors++; $display("FAIL rstmid_next_valid got %b want 1", o_valid[4]); end
    checks++; if ({o_diag[4], o_up[4], o_left[4]} !== 24'hD9DAE2) begin errors++; $display("FAIL rstmid_next_scores got %h want d9dae2", {o_diag[4], o_up[4], o_left[4]}); end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 8'(a - 40);
    bus.req      = 1'b0;
    bus.row_i    = '0;
    bus.col_j    = '0;
    bus.ram_dout = '0;
    test_reset();
    test_single();
    test_mid_cell();
    test_reject();
    test_corner();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
